// File: rtl/future_rk_sched.sv
`default_nettype none
// ============================================================================
// future_rk_sched : self-timed FUTURE round-key scheduler (fwd/rev order)
// Rev 1.0
// ============================================================================
module future_rk_sched #(
  parameter int unsigned W     = 64,
  parameter int unsigned NR    = 10,
  parameter int unsigned KROT  = 5,
  parameter int unsigned RCROT = 16,
  localparam int unsigned IW   = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          mode,
  input  logic [W-1:0]  k0_in,
  input  logic [W-1:0]  k1_in,
  input  logic [W-1:0]  rc_in,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [W-1:0]  rk_out,
  output logic [IW-1:0] rk_idx,
  output logic          rk_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [IW-1:0] C_LAST_IDX = IW'(NR - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  k0_q, k0_d, k1_q, k1_d, rc_q, rc_d;
  logic          mode_q, mode_d;
  logic          rk_valid_q, rk_valid_d;
  logic [W-1:0]  rk_out_q, rk_out_d;
  logic [IW-1:0] rk_idx_q, rk_idx_d;
  logic          rk_last_q, rk_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          present;
  logic [IW-1:0] r_sel;
  logic [W-1:0]  k0_sel, k1_sel, rc_sel;
  logic          mode_sel;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int unsigned sh);
    rotl = (sh == 0) ? x : ((x << sh) | (x >> (W - sh)));
  endfunction

  // Rotation amounts come straight from r, so either order starts without pre-roll.
  function automatic logic [W-1:0] round_key(input logic [IW-1:0] r,
                                             input logic [W-1:0]  k0,
                                             input logic [W-1:0]  k1,
                                             input logic [W-1:0]  rc);
    int unsigned ri;
    ri        = 32'(r);
    round_key = rotl(r[0] ? k1 : k0, (KROT * (ri >> 1)) % W) ^ rotl(rc, (RCROT * ri) % W);
  endfunction

  always_comb begin
    state_d    = state_q;
    k0_d       = k0_q;
    k1_d       = k1_q;
    rc_d       = rc_q;
    mode_d     = mode_q;
    rk_valid_d = rk_valid_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rk_last_d  = rk_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    present    = 1'b0;
    r_sel      = rk_idx_q;
    k0_sel     = k0_q;
    k1_sel     = k1_q;
    rc_sel     = rc_q;
    mode_sel   = mode_q;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d  = ST_RUN;
          k0_d     = k0_in;
          k1_d     = k1_in;
          rc_d     = rc_in;
          mode_d   = mode;
          k0_sel   = k0_in;
          k1_sel   = k1_in;
          rc_sel   = rc_in;
          mode_sel = mode;
          r_sel    = mode ? C_LAST_IDX : '0;
          present  = 1'b1;
        end
      end
      ST_RUN: begin
        if (rk_ready) begin
          if (rk_last_q) begin
            state_d    = ST_IDLE;
            rk_valid_d = 1'b0;
            rk_out_d   = '0;
            rk_idx_d   = '0;
            rk_last_d  = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            r_sel   = mode_q ? (rk_idx_q - IW'(1)) : (rk_idx_q + IW'(1));
            present = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (present) begin
      rk_valid_d = 1'b1;
      busy_d     = 1'b1;
      rk_out_d   = round_key(r_sel, k0_sel, k1_sel, rc_sel);
      rk_idx_d   = r_sel;
      rk_last_d  = mode_sel ? (r_sel == '0) : (r_sel == C_LAST_IDX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k0_q       <= '0;
      k1_q       <= '0;
      rc_q       <= '0;
      mode_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
      rk_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k0_q       <= k0_d;
      k1_q       <= k1_d;
      rc_q       <= rc_d;
      mode_q     <= mode_d;
      rk_valid_q <= rk_valid_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rk_last_q  <= rk_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_out_q;
  assign rk_idx   = rk_idx_q;
  assign rk_last  = rk_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_future_rk_sched.sv
`default_nettype none
// ============================================================================
// tb_future_rk_sched : bench for future_rk_sched against a behavioural model
// Rev 1.0
// ============================================================================
module tb_future_rk_sched;

  localparam int W = 64, NR = 10, KROT = 5, RCROT = 16, IW = 4;

  logic          clk = 1'b0;
  logic          rst, load, mode, rk_ready;
  logic [W-1:0]  k0_in, k1_in, rc_in;
  logic          rk_valid, rk_last, busy, done;
  logic [W-1:0]  rk_out;
  logic [IW-1:0] rk_idx;

  // Single-round instance for the NR=1 corner
  logic          s_load, s_ready, s_valid, s_last, s_busy, s_done;
  logic [7:0]    s_k0, s_k1, s_rc, s_out;
  logic [0:0]    s_idx;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  future_rk_sched #(.W(W), .NR(NR), .KROT(KROT), .RCROT(RCROT)) u_dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode),
    .k0_in(k0_in), .k1_in(k1_in), .rc_in(rc_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
    .rk_idx(rk_idx), .rk_last(rk_last), .busy(busy), .done(done)
  );

  future_rk_sched #(.W(8), .NR(1), .KROT(3), .RCROT(5)) u_dut1 (
    .clk(clk), .rst(rst), .load(s_load), .mode(1'b0),
    .k0_in(s_k0), .k1_in(s_k1), .rc_in(s_rc),
    .rk_valid(s_valid), .rk_ready(s_ready), .rk_out(s_out),
    .rk_idx(s_idx), .rk_last(s_last), .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Reference model: rotate one bit at a time, straight from the round-key formula
  function automatic logic [W-1:0] rotl_m(input logic [W-1:0] x, input int n);
    for (int i = 0; i < n; i++) x = {x[W-2:0], x[W-1]};
    return x;
  endfunction

  function automatic logic [W-1:0] model_key(input int r, input logic [W-1:0] k0,
                                             input logic [W-1:0] k1, input logic [W-1:0] rc);
    logic [W-1:0] kb;
    kb = (r % 2 == 0) ? k0 : k1;
    return rotl_m(kb, (KROT * (r / 2)) % W) ^ rotl_m(rc, (RCROT * r) % W);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, W'(rk_valid), '0);
    chk({tag, ".out"},   rk_out,       '0);
    chk({tag, ".idx"},   W'(rk_idx),   '0);
    chk({tag, ".last"},  W'(rk_last),  '0);
    chk({tag, ".busy"},  W'(busy),     '0);
  endtask

  // Runs a full sequence; abort_at >= 0 applies rst when that many keys were accepted.
  task automatic run_seq(input string tag, input logic m, input logic [W-1:0] k0,
                         input logic [W-1:0] k1, input logic [W-1:0] rc,
                         input bit rnd_ready, input bit mid_load, input int abort_at);
    int order[$];
    int i, cyc;
    for (int j = 0; j < NR; j++) order.push_back(m ? NR - 1 - j : j);
    mode = m; k0_in = k0; k1_in = k1; rc_in = rc; load = 1'b1; rk_ready = 1'b1;
    tick();
    load = 1'b0;
    k0_in = {$urandom, $urandom}; k1_in = {$urandom, $urandom}; rc_in = {$urandom, $urandom};
    mode = ~m;
    i = 0; cyc = 0;
    while (i < NR) begin
      if (cyc > 200) begin
        chk({tag, ".timeout"}, W'(i), W'(NR));
        return;
      end
      if (i == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle({tag, ".rst"});
        chk({tag, ".rst.done"}, W'(done), '0);
        tick();
        chk({tag, ".rst.done2"}, W'(done), '0);
        return;
      end
      chk({tag, ".valid"}, W'(rk_valid), 1);
      chk({tag, ".busy"},  W'(busy), 1);
      chk({tag, ".done"},  W'(done), 0);
      chk({tag, ".key"},   rk_out, model_key(order[i], k0, k1, rc));
      chk({tag, ".idx"},   W'(rk_idx), W'(order[i]));
      chk({tag, ".last"},  W'(rk_last), W'(i == NR - 1));
      rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      load     = mid_load ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      load = 1'b0;
      if (rk_ready) i++;
      cyc++;
    end
    chk_idle({tag, ".end"});
    chk({tag, ".done"}, W'(done), 1);
    tick();
    chk({tag, ".done_drop"}, W'(done), 0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; mode = 1'b0; rk_ready = 1'b0;
    k0_in = '0; k1_in = '0; rc_in = '0;
    s_load = 1'b0; s_ready = 1'b1; s_k0 = '0; s_k1 = '0; s_rc = '0;
    tick(); tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset.done", W'(done), '0);

    // RC walk forward, with literal spot checks on the first keys
    mode = 1'b0; k0_in = '0; k1_in = '0; rc_in = 64'h1; load = 1'b1; rk_ready = 1'b1;
    tick();
    load = 1'b0;
    chk("rcwalk.r0", rk_out, 64'h1);
    tick();
    chk("rcwalk.r1", rk_out, 64'h10000);
    tick();
    chk("rcwalk.r2", rk_out, 64'h1_0000_0000);
    tick();
    chk("rcwalk.r3", rk_out, 64'h1_0000_0000_0000);
    for (int j = 4; j < NR; j++) tick();
    chk("rcwalk.r9", rk_out, 64'h10000);
    chk("rcwalk.r9last", W'(rk_last), 1);
    tick();
    chk("rcwalk.done", W'(done), 1);

    run_seq("rcfwd", 1'b0, '0, '0, 64'h1, 1'b0, 1'b0, -1);
    run_seq("keyrot", 1'b0, 64'h1, '0, '0, 1'b0, 1'b0, -1);
    run_seq("rev", 1'b1, '0, '0, 64'h1, 1'b0, 1'b0, -1);

    // Combined key and constant, first key literal
    mode = 1'b0; k0_in = 64'h2382bcde3298abcd; k1_in = '0; rc_in = 64'h1248248148128124;
    load = 1'b1; rk_ready = 1'b0;
    tick();
    load = 1'b0;
    chk("combo.r0", rk_out, 64'h31ca985f7a8a2ae9);
    rk_ready = 1'b1;
    for (int j = 0; j < NR; j++) tick();
    chk("combo.done", W'(done), 1);

    // Load in the done cycle is accepted immediately
    run_seq("b2b", 1'b0, 64'hdeadbeef01234567, 64'h0f1e2d3c4b5a6978, 64'h1248248148128124, 1'b0, 1'b0, -1);

    for (int t = 0; t < 4; t++)
      run_seq("stall", 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, 1'b1, 1'b1, -1);

    run_seq("abort", 1'b0, 64'h1, 64'h2, 64'h1, 1'b1, 1'b0, 4);
    run_seq("restart", 1'b0, 64'h1, 64'h2, 64'h1, 1'b0, 1'b0, -1);
    run_seq("revrnd", 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            1'b1, 1'b0, -1);

    // NR=1: single key is also the last
    s_k0 = 8'hA5; s_k1 = 8'h77; s_rc = 8'h3C; s_load = 1'b1;
    tick();
    s_load = 1'b0;
    chk("nr1.valid", W'(s_valid), 1);
    chk("nr1.last",  W'(s_last), 1);
    chk("nr1.idx",   W'(s_idx), 0);
    chk("nr1.key",   W'(s_out), W'(8'h99));
    tick();
    chk("nr1.done",  W'(s_done), 1);
    chk("nr1.valid2", W'(s_valid), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
